// File: rtl/if_halt_stage_pkg.sv
// if_halt_stage_pkg: shared FSM encoding and instruction constants for the fetch stage
package if_halt_stage_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    STOPPED = 2'd2
  } state_e;
  localparam logic [31:0] HALT_WORD_C = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
endpackage

// File: rtl/if_halt_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush-to-NOP
module if_id_reg
  import if_halt_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  always_comb begin
    instr_d = flush_i ? NOP  : load_i ? instr_i : instr_q;
    pc4_d   = flush_i ? '0   : load_i ? pc4_i   : pc4_q;
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1    : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_halt_stage.sv
// if_halt_stage: MIPS fetch stage owning the PC, IF/ID register, and halt-drain-stop sequencing
module if_halt_stage
  import if_halt_stage_pkg::*;
#(
  parameter int          IMEM_AW      = 9,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_C,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic [31:0]        imem_data_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        ifid_instr_o,
  output logic [31:0]        ifid_pc4_o,
  output logic               ifid_valid_o,
  output logic               stop_o,
  output logic [31:0]        cycle_count_o
);
  localparam int CW = $clog2(DRAIN_CYCLES) + 1;
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, cyc_q, cyc_d, pc4;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stop_q, stop_d, load, flush;
  assign pc4 = pc_q + 32'd4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    load    = 1'b0;
    flush   = 1'b0;
    cyc_d   = (state_q != STOPPED && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i & ~32'h3;
          flush = 1'b1;
        end else if (!stall_i) begin
          if (imem_data_i == HALT_WORD) begin
            flush   = 1'b1;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
            state_d = DRAIN;
          end else begin
            load = 1'b1;
            pc_d = pc4;
          end
        end
      end
      DRAIN: begin
        flush = 1'b1;
        if (redirect_i) begin
          pc_d    = redirect_pc_i & ~32'h3;
          cnt_d   = '0;
          state_d = RUN;
        end else if (!stall_i) begin
          if (cnt_q == '0) begin
            state_d = STOPPED;
            stop_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      cyc_q   <= cyc_d;
    end
  end
  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (imem_data_i),
    .pc4_i   (pc4),
    .instr_o (ifid_instr_o),
    .pc4_o   (ifid_pc4_o),
    .valid_o (ifid_valid_o)
  );
  assign imem_addr_o   = pc_q[IMEM_AW+1:2];
  assign pc_o          = pc_q;
  assign stop_o        = stop_q;
  assign cycle_count_o = cyc_q;
endmodule

// File: doc/if_halt_stage.md
Name: if_halt_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory word address.
- Loads the IF/ID pipeline register and handles hazard stalls and branch/jump redirects.
- Detects the halt word and drains the downstream pipeline before asserting the CPU-level stop.

Parameters:
- IMEM_AW, 9, instruction-memory word-address width (512 words).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates the program.
- DRAIN_CYCLES, 4, non-stalled cycles needed to retire in-flight instructions (ID, EX, MEM, WB).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit freeze of PC and IF/ID.
- redirect_i  in  1  taken branch or jump resolved downstream; flush IF/ID.
- redirect_pc_i  in  32  redirect target byte address.
- imem_data_i  in  32  instruction word at imem_addr_o (combinational read).
- imem_addr_o  out  IMEM_AW  equals pc_o[IMEM_AW+1:2].
- pc_o  out  32  current fetch PC.
- ifid_instr_o  out  32  IF/ID instruction register.
- ifid_pc4_o  out  32  IF/ID PC+4 register.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- stop_o  out  1  registered, sticky; high once the pipeline has drained after a halt.
- cycle_count_o  out  32  cycles since reset release; frozen when stop_o rises.

Behaviour:
- Reset is synchronous, applied at the rising edge while rst=1, and is valid in any state. Reset values:
  - pc_o=0, ifid_instr_o=0 (NOP), ifid_pc4_o=0, ifid_valid_o=0.
  - stop_o=0, cycle_count_o=0, state=RUN, drain counter=0.
- FSM states: RUN, DRAIN, STOPPED.
- RUN, priority order at each edge:
  1. redirect_i: pc<=redirect_pc_i; IF/ID<=NOP with valid=0. Redirect beats stall.
  2. stall_i: PC and IF/ID hold.
  3. imem_data_i==HALT_WORD: PC holds; IF/ID<=NOP with valid=0 (halt is never passed downstream); counter<=DRAIN_CYCLES-1; go to DRAIN.
  4. Otherwise: IF/ID<={imem_data_i, pc+4, valid=1}; pc<=pc+4.
- DRAIN:
  - PC frozen; IF/ID held at NOP.
  - redirect_i: the halt was on a wrong path. pc<=redirect_pc_i; IF/ID NOP; return to RUN; counter cleared.
  - stall_i: counter holds, because the stalled instruction has not yet advanced.
  - Otherwise: if counter==0, go to STOPPED and set stop_o<=1; else decrement the counter.
  - stop_o therefore rises exactly DRAIN_CYCLES non-stalled edges after the halt was captured.
- STOPPED:
  - Sticky until rst.
  - PC, IF/ID and cycle_count_o frozen.
  - stall_i and redirect_i ignored.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - imem_addr_o truncates the PC, so fetches beyond the memory depth alias.
  - PC bits [1:0] are always 0; a misaligned redirect target is forced to [1:0]=0.
  - cycle_count_o increments every non-reset cycle while state != STOPPED and saturates at 32'hFFFF_FFFF.
- Latency: instruction at PC appears on ifid_* one edge after PC is presented. No combinational path from any input to any registered output except imem_addr_o, which derives from pc_o only.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit: RUN=0, DRAIN=1, STOPPED=2).
  - HALT_WORD and NOP constants.
  - PC reset vector (0).
- One natural sub-module, if_id_reg: the IF/ID register with load, hold and flush controls. The FSM and PC logic live in the parent.

Test Plan:
- Reset: hold rst 2 cycles mid-run -> next edge pc_o=0, ifid_valid_o=0, stop_o=0, cycle_count_o=0, imem_addr_o=0.
- Straight line then halt: words 0..3 = 0x20010001..0x20040004, word4=HALT -> ifid_pc4_o sequence 4, 8, 12, 16 with valid=1. Halt captured at edge 5. pc_o stays 0x10. stop_o rises at edge 9, cycle_count_o=9.
- Stall: stall_i=1 for 2 cycles while IF/ID holds the word from 0x8 -> ifid_instr_o and pc_o=0xC unchanged both cycles, then fetch from 0xC resumes.
- Redirect with simultaneous stall: redirect_pc_i=0x40, stall_i=1 -> pc_o=0x40, ifid_valid_o=0 next edge.
- Wrong-path halt: halt captured; redirect_i to 0x20 after 2 drain edges -> state RUN, pc_o=0x20, stop_o stays 0; a later halt drains normally.
- Drain with stall, then reset while stopped:
  - stall_i=1 for 3 cycles during DRAIN -> stop_o delayed by exactly 3 cycles.
  - Then assert rst while STOPPED -> stop_o=0 and pc_o=0 next edge.
